// File: rtl/key_code_fifo.sv
// key_code_fifo
//   Debounces the 4-bit priority-encoder code and queues each newly settled active index in a
//   small FIFO. The FIFO is drained through a valid/ready port.
//
// Parameters
//   DEPTH     FIFO entries (power of two, 2..16)
//   STABLE    edges the synchronised code must hold before acceptance (1..15)
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   x          encoder code: x[3] any-active, x[2:0] index (asynchronous to clk)
//   out_ready  consumer takes the head entry this cycle
//   ovf_clr    synchronous clear of the sticky overflow flag
//   code_out   index at FIFO head, 0 when empty
//   out_valid  FIFO non-empty
//   count      entries held, 0..DEPTH
//   overflow   sticky: an event was dropped because the FIFO was full
module key_code_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               x,
    input  logic                     out_ready,
    input  logic                     ovf_clr,
    output logic [2:0]               code_out,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  StableCnt = 4'(STABLE);
    localparam logic [AW:0] FullCnt   = (AW + 1)'(DEPTH);

    logic [3:0]  s1_q, s2_q, prev_q, acc_q, cnt_q;
    logic [AW:0] wptr_q, rptr_q;
    logic [2:0]  mem_q [DEPTH];
    logic        overflow_q;

    logic accept, push, pop, full, empty, wr_en, drop;

    always_comb begin
        // A settled code is accepted only once; acc remembers the last accepted code,
        // so a release (x[3] = 0) re-arms the same index.
        accept    = (cnt_q == StableCnt) && (prev_q != acc_q);
        push      = accept && prev_q[3];
        count     = wptr_q - rptr_q;
        empty     = (wptr_q == rptr_q);
        full      = (count == FullCnt);
        pop       = !empty && out_ready;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        wr_en     = push && (!full || pop);
        drop      = push && full && !pop;
        out_valid = !empty;
        code_out  = empty ? 3'd0 : mem_q[rptr_q[AW-1:0]];
        overflow  = overflow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 4'd0;
            s2_q       <= 4'd0;
            prev_q     <= 4'd0;
            acc_q      <= 4'd0;
            cnt_q      <= 4'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_q   <= x;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            if (s2_q != prev_q) begin
                cnt_q <= 4'd0;
            end else if (cnt_q != StableCnt) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (accept) begin
                acc_q <= prev_q;
            end
            if (wr_en) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            // A drop wins over a coincident clear.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= prev_q[2:0];
        end
    end

endmodule
